// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU constants: serial-subtractor FSM state encoding
//                and the default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int C_DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor4bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor4bit_if
//  Description : Start/busy/done request bus between the controlling FSM
//                (master) and the bit-serial subtractor (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor4bit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             carryout;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, carryout, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, carryout, overflow
    );

endinterface
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_cell
//  Description : Combinational 1-bit full adder, the same cell the ripple
//                adder is built from.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      sum,
    output logic      cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor4bit.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor4bit
//  Description : Bit-serial two's-complement subtractor, diff = a - b,
//                computed LSB-first as a + ~b + 1 with one full-adder step
//                per clock. Result, carry-out and overflow follow the ripple
//                adder's conventions so the two paths can be cross-checked.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor4bit
    import alu_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    serial_subtractor4bit_if.slave bus
);

    localparam int                 C_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [C_CNT_W-1:0] r_count;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [WIDTH-1:0]   r_diff;
    logic               r_carryout;
    logic               r_overflow;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_sum;
    logic               w_cout;

    // A new request is taken whenever no operation is running, which
    // includes the DONE cycle so operations can run back-to-back.
    assign w_load = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_step = (r_state == ST_SHIFT);
    assign w_last = w_step && (r_count == C_LAST);

    // Single adder cell, reused every cycle on the current LSBs.
    full_adder_cell u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Control FSM: state, bit counter and the busy/done handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_load) begin
                        r_state <= ST_SHIFT;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_count <= r_count + C_CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand shifters and running carry; carry starts at 1 for the +1 of
    // negating b, and sum bits enter the result register from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
        end else if (w_load) begin
            r_a     <= bus.a;
            r_b     <= ~bus.b;
            r_res   <= '0;
            r_carry <= 1'b1;
        end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= {w_sum, r_res[WIDTH-1:1]};
            r_carry <= w_cout;
        end
    end

    // Visible result updates only on the final step; on that step r_carry
    // is the carry into the MSB, so overflow is r_carry XOR carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff     <= '0;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_last) begin
            r_diff     <= {w_sum, r_res[WIDTH-1:1]};
            r_carryout <= w_cout;
            r_overflow <= r_carry ^ w_cout;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.diff     = r_diff;
    assign bus.carryout = r_carryout;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor4bit
//  Description : Self-checking bench for serial_subtractor4bit: table of
//                hand-derived vectors, handshake corner cases and an
//                exhaustive back-to-back sweep, checked through a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor4bit;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         co;
        logic         ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_subtractor4bit_if #(.WIDTH(W)) bus();

    serial_subtractor4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t sb_q[$];
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference from integer arithmetic on the signed/unsigned operand values.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        int   sa;
        int   sb;
        int   r;
        sa     = $signed(a);
        sb     = $signed(b);
        r      = sa - sb;
        v.a    = a;
        v.b    = b;
        v.diff = r[W-1:0];
        v.co   = (a >= b);
        v.ov   = (r < -(2 ** (W - 1))) || (r > (2 ** (W - 1)) - 1);
        return v;
    endfunction

    // Every done pulse consumes exactly one expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                chk($sformatf("diff a=%0h b=%0h", e.a, e.b), bus.diff, e.diff);
                chk($sformatf("carryout a=%0h b=%0h", e.a, e.b), bus.carryout, e.co);
                chk($sformatf("overflow a=%0h b=%0h", e.a, e.b), bus.overflow, e.ov);
                chk("busy_at_done", bus.busy, 32'd0);
            end
        end
    end

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input vec_t exp);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        sb_q.push_back(exp);
    endtask

    // Counts negedges until done is seen. From the negedge that drove start,
    // edges E0..E(W) put done in view on negedge number W+1.
    task automatic wait_done(input bit drop_start, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop_start) bus.start = 1'b0;
        end while (bus.done !== 1'b1 && n < 20);
        chk("latency", n, exp_n);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{a: 4'h7, b: 4'h3, diff: 4'h4, co: 1'b1, ov: 1'b0};
        tbl[1] = '{a: 4'h7, b: 4'hF, diff: 4'h8, co: 1'b0, ov: 1'b1};
        tbl[2] = '{a: 4'h8, b: 4'h1, diff: 4'h7, co: 1'b1, ov: 1'b1};
        tbl[3] = '{a: 4'hD, b: 4'hD, diff: 4'h0, co: 1'b1, ov: 1'b0};
        tbl[4] = '{a: 4'h0, b: 4'h0, diff: 4'h0, co: 1'b1, ov: 1'b0};
        tbl[5] = '{a: 4'h3, b: 4'h7, diff: 4'hC, co: 1'b0, ov: 1'b0};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_done", bus.done, 32'd0);
        chk("rst_diff", bus.diff, 32'd0);
        chk("rst_carryout", bus.carryout, 32'd0);
        chk("rst_overflow", bus.overflow, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", bus.busy, 32'd0);
        chk("post_rst_diff", bus.diff, 32'd0);

        // Table vectors, one idle cycle between operations.
        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].a, tbl[i].b, tbl[i]);
            wait_done(1'b1, W + 1);
            @(negedge clk);
            chk("hold_idle_diff", bus.diff, tbl[i].diff);
            chk("idle_done_low", bus.done, 32'd0);
        end

        // start pulsed mid-SHIFT with other operands must be ignored.
        launch(4'h7, 4'h3, tbl[0]);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'h1;
        bus.b     = 4'h1;
        chk("busy_mid_shift", bus.busy, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        chk("hold_in_shift_diff", bus.diff, 32'hC);
        wait_done(1'b1, W - 2);
        repeat (4) @(negedge clk);
        chk("idle_after_ignored", bus.busy, 32'd0);

        // start held high through the op and into DONE: next op starts at once.
        launch(4'h5, 4'h2, model(4'h5, 4'h2));
        wait_done(1'b0, W + 1);
        launch(4'h8, 4'h1, model(4'h8, 4'h1));
        wait_done(1'b1, W + 1);
        @(negedge clk);

        // Reset during cycle 2 of an operation: abort, outputs cleared, no done.
        bus.start = 1'b1;
        bus.a     = 4'h6;
        bus.b     = 4'h1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 32'd0);
        chk("abort_done", bus.done, 32'd0);
        chk("abort_diff", bus.diff, 32'd0);
        chk("abort_carryout", bus.carryout, 32'd0);
        chk("abort_overflow", bus.overflow, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_stays_idle", bus.busy, 32'd0);
        chk("abort_diff_kept_zero", bus.diff, 32'd0);

        // Exhaustive sweep, each launch issued in the previous DONE cycle.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                launch(ai[W-1:0], bi[W-1:0], model(ai[W-1:0], bi[W-1:0]));
                wait_done(1'b1, W + 1);
            end
        end

        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor4bit.md
Name: serial_subtractor4bit

Overview:
- Bit-serial two's-complement subtractor: diff = a - b, computed LSB-first, one bit per clock.
- Inverse operation of the combinational 4-bit full adder. It reuses the same sum/carryout/overflow conventions, so results can be cross-checked against that adder.
- Sits beside the adder in the ALU datapath as the low-area subtract path.
- Uses a start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend, two's complement; sampled with start
- b  input  WIDTH  subtrahend, two's complement; sampled with start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when the result is valid
- diff  output  WIDTH  result a-b, modulo 2^WIDTH
- carryout  output  1  final carry of a + ~b + 1; 1 means no borrow (unsigned a >= b)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy, done, diff, carryout and overflow all go to 0.
  - Internal shift registers, carry and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: latch a into the A shift register and ~b into the B shift register.
  - carry := 1 (the +1 of two's-complement negation), count := 0, go to SHIFT, busy := 1.
- SHIFT:
  - At edge E(i+1), i = 0..WIDTH-1, one full-adder step on A[0], B[0] and carry.
  - The sum bit shifts into the MSB of the result register; A and B shift right; carry := cout.
  - At i = WIDTH-1, save the carry-in to the MSB for overflow.
- Completion, at edge E(WIDTH):
  - diff, carryout and overflow update together from the internal result.
  - done := 1, busy := 0, go to DONE.
  - Latency is exactly WIDTH cycles from the start edge to the done edge.
- DONE:
  - Lasts one cycle; done returns to 0 at the next edge.
  - start=1 in DONE is accepted exactly as in IDLE, which allows back-to-back operations with no gap.
  - Otherwise go to IDLE.
- Output hold: diff, carryout and overflow change only at completion. They hold the last result through IDLE and through the next operation's SHIFT.
- start while busy=1 is ignored; operand changes during SHIFT have no effect.
- Reset asserted mid-operation aborts immediately. No done pulse follows, and the outputs read 0.
- Width rules:
  - Internal carry is 1 bit; the counter is clog2(WIDTH)+1 bits.
  - diff wraps modulo 2^WIDTH.
  - Overflow follows the adder's definition applied to a + (~b) + 1.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the default WIDTH constant.
- One sub-module, full_adder_cell: combinational 1-bit a, b, cin → sum, cout. It is the same cell used by the ripple adder, instantiated once and reused each cycle.

Test Plan:
- Post-reset: rst_n=0 then 1 → busy=0, done=0, diff=0000, carryout=0, overflow=0.
- Positive, no overflow: start with a=7, b=3 → done exactly 4 cycles later; diff=4 (0100), carryout=1, overflow=0.
- Signed overflow, both directions:
  - a=7, b=-1 → diff=1000 (-8), carryout=0, overflow=1.
  - a=-8, b=1 → diff=0111, carryout=1, overflow=1.
- Equality and zero:
  - a=-3, b=-3 → diff=0000, carryout=1, overflow=0.
  - a=0, b=0 → diff=0000, carryout=1, overflow=0.
- Handshake edge cases:
  - start pulsed again during SHIFT with a=1, b=1 → ignored; the first result (7-3=4) is delivered.
  - start held high in the DONE cycle → the next result arrives 4 cycles later.
  - rst_n low at cycle 2 of an operation → no done; all outputs 0.
- Exhaustive: all 256 (a,b) pairs in -8..7 back-to-back. diff must equal (a-b) mod 16, carryout must equal (a_unsigned >= b_unsigned), overflow must equal (a-b outside -8..7).
